// File: rtl/mm_arbiter.sv
// Round-robin arbiter sharing one matrix multiply controller among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining MM_ARB_TIMEOUT_EN.
module mm_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         ack,
    output logic [$clog2(NUM_REQ)-1:0] sel,
    output logic                       mm_start,
    input  logic                       mm_done,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int SW = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic [SW-1:0]      rr_q, rr_d;
    logic               pick_found;
    logic [SW-1:0]      pick_idx;
    logic [SW:0]        scan;

    // Cyclic search starting at rr_q; scan is one bit wider so the wrap never overflows.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_q} + (SW+1)'(k);
            if (scan >= (SW+1)'(NUM_REQ)) begin
                scan = scan - (SW+1)'(NUM_REQ);
            end
            if (!pick_found && req[scan[SW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[SW-1:0];
            end
        end
    end

`ifdef MM_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
`ifdef MM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    sel_d   = pick_idx;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef MM_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (mm_done) begin
                    state_d = ACK;
                end
`ifdef MM_ARB_TIMEOUT_EN
                // Done in the same cycle as expiry wins and reports no error.
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ACK;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = '0;
                if (sel_q == SW'(NUM_REQ - 1)) begin
                    rr_d = '0;
                end else begin
                    rr_d = sel_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            rr_q    <= '0;
`ifdef MM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
`ifdef MM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign ack      = (state_q == ACK) ? gnt_q : '0;
    assign mm_start = (state_q == START);
    assign busy     = (state_q != IDLE);

`ifdef MM_ARB_TIMEOUT_EN
    assign timeout_err = to_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mm_arbiter.sv
// Testbench for mm_arbiter: grant/ack scoreboard plus per-scenario checks.
// Timeout scenario adapts to whether MM_ARB_TIMEOUT_EN is defined.
module tb_mm_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [1:0] sel;
    logic       mm_start;
    logic       mm_done;
    logic       busy;
    logic       timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;
    int n_acks  = 0;
    int n_te    = 0;
    logic [3:0] exp_q[$];
    logic [3:0] e;

    mm_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .ack(ack),
        .sel(sel), .mm_start(mm_start), .mm_done(mm_done), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard: every ack must match the next expected grant.
    always @(negedge clk) begin
        n_tests++;
        if (!$onehot0(gnt) || (ack != 4'b0 && ack != gnt)) begin
            n_fail++;
            $display("FAIL invariant: gnt=%b ack=%b, required gnt onehot0 and ack 0 or gnt", gnt, ack);
        end
        if (mm_start) n_starts++;
        if (timeout_err) n_te++;
        if (ack != 4'b0) begin
            n_acks++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: ack=%b, required no ack", ack);
            end else begin
                e = exp_q.pop_front();
                if (ack !== e) begin
                    n_fail++;
                    $display("FAIL sb_ack: ack=%b, required %b", ack, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (mm_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b0;
        mm_done = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({gnt, ack, sel, mm_start, busy, timeout_err} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_outs: gnt=%b ack=%b sel=%0d start=%b busy=%b te=%b, required all 0",
                     gnt, ack, sel, mm_start, busy, timeout_err);
        end
        reset_n = 1'b1;
        tick();
        tick();
        n_tests++;
        if (busy !== 1'b0 || mm_start !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_noreq: busy=%b start=%b, required 0 0", busy, mm_start);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] eg;
        int s0, a0;
        s0 = n_starts;
        a0 = n_acks;
        req = 4'b1111;
        for (int j = 0; j < 8; j++) exp_q.push_back(4'b0001 << (j % 4));
        for (int j = 0; j < 8; j++) begin
            eg = 4'b0001 << (j % 4);
            wait_start(ok);
            n_tests++;
            if (!ok || gnt !== eg || sel !== 2'(j % 4)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: ok=%b gnt=%b sel=%0d, required gnt=%b sel=%0d",
                         j, ok, gnt, sel, eg, j % 4);
            end
            tick();
            tick();
            mm_done = 1'b1;
            tick();
            mm_done = 1'b0;
            if (j == 7) req = 4'b0;
        end
        tick();
        tick();
        n_tests++;
        if (n_starts - s0 != 8 || n_acks - a0 != 8) begin
            n_fail++;
            $display("FAIL rr_counts: starts=%0d acks=%0d, required 8 8",
                     n_starts - s0, n_acks - a0);
        end
    endtask

    task automatic test_single();
        int s0;
        s0 = n_starts;
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        tick();
        n_tests++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || mm_start !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_t1: gnt=%b sel=%0d start=%b busy=%b, required 0100 2 1 1",
                     gnt, sel, mm_start, busy);
        end
        for (int i = 0; i < 20; i++) tick();
        n_tests++;
        if (mm_start !== 1'b0 || ack !== 4'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_wait: start=%b ack=%b busy=%b, required 0 0000 1",
                     mm_start, ack, busy);
        end
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        req = 4'b0;
        n_tests++;
        if (ack !== 4'b0100 || gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b gnt=%b, required 0100 0100", ack, gnt);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || gnt !== 4'b0 || n_starts - s0 != 1) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b gnt=%b starts=%0d, required 0 0000 1",
                     busy, gnt, n_starts - s0);
        end
    endtask

    task automatic test_drop();
        req = 4'b0010;
        mm_done = 1'b1;
        exp_q.push_back(4'b0010);
        tick();
        n_tests++;
        if (mm_start !== 1'b1 || gnt !== 4'b0010 || ack !== 4'b0) begin
            n_fail++;
            $display("FAIL drop_start: start=%b gnt=%b ack=%b, required 1 0010 0000",
                     mm_start, gnt, ack);
        end
        tick();
        mm_done = 1'b0;
        req = 4'b0;
        n_tests++;
        if (ack !== 4'b0 || busy !== 1'b1 || mm_start !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_wait: ack=%b busy=%b start=%b, required 0000 1 0",
                     ack, busy, mm_start);
        end
        tick();
        tick();
        tick();
        n_tests++;
        if (ack !== 4'b0 || busy !== 1'b1 || gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_hold: ack=%b busy=%b gnt=%b, required 0000 1 0010",
                     ack, busy, gnt);
        end
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        n_tests++;
        if (ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_ack: ack=%b, required 0010", ack);
        end
        tick();
        tick();
        n_tests++;
        if (busy !== 1'b0 || mm_start !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle: busy=%b start=%b, required 0 0", busy, mm_start);
        end
    endtask

    task automatic test_reset_mid();
        int a0;
        a0 = n_acks;
        req = 4'b0001;
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || mm_start !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_grant: gnt=%b start=%b, required 0001 1", gnt, mm_start);
        end
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        n_tests++;
        if ({gnt, ack, sel, mm_start, busy, timeout_err} !== 13'b0 || n_acks != a0) begin
            n_fail++;
            $display("FAIL rmid_reset: gnt=%b ack=%b sel=%0d start=%b busy=%b te=%b, required all 0",
                     gnt, ack, sel, mm_start, busy, timeout_err);
        end
        reset_n = 1'b1;
        exp_q.push_back(4'b0001);
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || mm_start !== 1'b1 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_regrant: gnt=%b start=%b sel=%0d, required 0001 1 0",
                     gnt, mm_start, sel);
        end
        tick();
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        req = 4'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || n_acks - a0 != 1) begin
            n_fail++;
            $display("FAIL rmid_done: busy=%b acks=%0d, required 0 1", busy, n_acks - a0);
        end
    endtask

    task automatic test_timeout();
        int t0;
        t0 = n_te;
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        tick();
        tick();
`ifdef MM_ARB_TIMEOUT_EN
        for (int i = 0; i < 63; i++) tick();
        n_tests++;
        if (ack !== 4'b0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: ack=%b busy=%b te=%b, required 0000 1 0",
                     ack, busy, timeout_err);
        end
        tick();
        n_tests++;
        if (ack !== 4'b1000 || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL to_fire: ack=%b te=%b, required 1000 1", ack, timeout_err);
        end
        tick();
        n_tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_after: te=%b busy=%b, required 0 0", timeout_err, busy);
        end
        exp_q.push_back(4'b1000);
        tick();
        tick();
        for (int i = 0; i < 63; i++) tick();
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        req = 4'b0;
        n_tests++;
        if (ack !== 4'b1000 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_tie: ack=%b te=%b, required 1000 0", ack, timeout_err);
        end
        tick();
        n_tests++;
        if (n_te - t0 != 1) begin
            n_fail++;
            $display("FAIL to_count: pulses=%0d, required 1", n_te - t0);
        end
`else
        for (int i = 0; i < 100; i++) tick();
        n_tests++;
        if (busy !== 1'b1 || ack !== 4'b0 || n_te != t0) begin
            n_fail++;
            $display("FAIL nowd_hold: busy=%b ack=%b te_pulses=%0d, required 1 0000 0",
                     busy, ack, n_te - t0);
        end
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
        req = 4'b0;
        n_tests++;
        if (ack !== 4'b1000 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL nowd_ack: ack=%b te=%b, required 1000 0", ack, timeout_err);
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_drop();
        test_reset_mid();
        test_timeout();
        tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
